// File: rtl/classifier_argmax_ctrl.sv
// classifier_argmax_ctrl: row sequencer and signed argmax over multiplier row scores.
// Optional per-row score readback bank enabled by ARGMAX_SCORE_BANK_EN.
module classifier_argmax_ctrl #(
  parameter int NUM_ROWS = 10,
  parameter int SCORE_W  = 16,
  parameter int ROW_W    = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  output logic               begin_mult,
  output logic [ROW_W-1:0]   row_select,
  input  logic               done_row,
  input  logic [SCORE_W-1:0] row_result,
  output logic               busy,
  output logic               result_valid,
  output logic [ROW_W-1:0]   class_out,
`ifdef ARGMAX_SCORE_BANK_EN
  input  logic [ROW_W-1:0]   score_sel,
  output logic [SCORE_W-1:0] score_rd,
`endif
  output logic [SCORE_W-1:0] max_score
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;
  state_t             state_q;
  logic               done_q, begin_q, busy_q, valid_q;
  logic [ROW_W-1:0]   row_q, class_q, run_idx_q, best_idx_d;
  logic [SCORE_W-1:0] max_q, run_max_q, best_max_d;
  logic               edge_d, upd_d, last_d;
  assign begin_mult   = begin_q;
  assign row_select   = row_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign class_out    = class_q;
  assign max_score    = max_q;
  always_comb begin
    edge_d     = done_row & ~done_q;
    upd_d      = (row_q == '0) || ($signed(row_result) > $signed(run_max_q));
    best_max_d = upd_d ? row_result : run_max_q;
    best_idx_d = upd_d ? row_q : run_idx_q;
    last_d     = row_q == ROW_W'(NUM_ROWS - 1);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      begin_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      row_q     <= '0;
      class_q   <= '0;
      max_q     <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
    end else begin
      done_q <= done_row;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_ISSUE;
          row_q   <= '0;
          begin_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          begin_q <= 1'b0;
        end
        S_WAIT: if (edge_d) state_q <= S_CAPTURE;
        S_CAPTURE: begin
          run_max_q <= best_max_d;
          run_idx_q <= best_idx_d;
          if (last_d) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            class_q <= best_idx_d;
            max_q   <= best_max_d;
          end else begin
            state_q <= S_ISSUE;
            row_q   <= row_q + 1'b1;
            begin_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef ARGMAX_SCORE_BANK_EN
  logic [SCORE_W-1:0] bank_q [NUM_ROWS];
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_ROWS; i++) bank_q[i] <= '0;
    end else if (state_q == S_CAPTURE) begin
      bank_q[row_q] <= row_result;
    end
  end
  assign score_rd = ({1'b0, score_sel} < (ROW_W+1)'(NUM_ROWS)) ? bank_q[score_sel] : '0;
`endif
endmodule
